// File: rtl/icetap_pkg.sv
// Shared constants for the icetap logic-analyser capture block.
package icetap_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_PREFILL = 3'd1;
    localparam logic [STATE_W-1:0] ST_ARMED   = 3'd2;
    localparam logic [STATE_W-1:0] ST_POST    = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/icetap_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module icetap_sample_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register reset only; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/icetap_capture.sv
// Triggered capture of probed signals into a circular sample buffer with
// configurable pre-trigger depth and sample-rate divider.
module icetap_capture
    import icetap_pkg::*;
#(
    parameter int unsigned NR_SIGNALS   = 8,
    parameter int unsigned RECORD_DEPTH = 256,
    localparam int unsigned ADDR_W      = $clog2(RECORD_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NR_SIGNALS-1:0] signals_in,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NR_SIGNALS-1:0] trig_mask,
    input  logic [NR_SIGNALS-1:0] trig_value,
    input  logic [NR_SIGNALS-1:0] trig_rise,
    input  logic [NR_SIGNALS-1:0] trig_fall,
    input  logic [ADDR_W-1:0]     pre_samples,
    input  logic [15:0]           sample_div,
    output logic [2:0]            state,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_W-1:0]     trig_addr,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [NR_SIGNALS-1:0] rd_data
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [NR_SIGNALS-1:0] mask_q, value_q, rise_q, fall_q, prev_q, prev_eff;
    logic [ADDR_W-1:0]     pre_q, pre_cnt_q, post_rem_q, wptr_q, post_len, rd_phys;
    logic [15:0]           div_q, tick_cnt_q;
    logic                  have_prev_q;
    logic                  capturing, tick, lvl_ok, rise_ok, fall_ok, hit;
    logic                  accept, fire;

    assign capturing = (state_q == ST_PREFILL) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign tick      = capturing && (tick_cnt_q == 16'd0);

    // Without a previous sample (no prefill) the current one stands in, so no edge is seen.
    assign prev_eff = have_prev_q ? prev_q : signals_in;
    assign lvl_ok   = ((signals_in ^ value_q) & mask_q) == '0;
    assign rise_ok  = (rise_q == '0) || ((rise_q & ~prev_eff & signals_in) != '0);
    assign fall_ok  = (fall_q == '0) || ((fall_q & prev_eff & ~signals_in) != '0);
    assign hit      = lvl_ok && rise_ok && fall_ok;

    assign post_len = ADDR_W'(RECORD_DEPTH - 1) - pre_q;
    assign rd_phys  = trig_addr - pre_q + rd_addr;

    assign state = state_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (pre_samples == '0) ? ST_ARMED : ST_PREFILL;
                end
            end
            ST_PREFILL: begin
                if (tick && (ADDR_W'(pre_cnt_q + ADDR_W'(1)) == pre_q)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (tick && hit) begin
                    fire    = 1'b1;
                    state_d = (post_len == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (tick && (post_rem_q == ADDR_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            accept  = 1'b0;
            fire    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            done        <= 1'b0;
            triggered   <= 1'b0;
            trig_addr   <= '0;
            wptr_q      <= '0;
            tick_cnt_q  <= '0;
            pre_cnt_q   <= '0;
            post_rem_q  <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            mask_q      <= '0;
            value_q     <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            pre_q       <= '0;
            div_q       <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == ST_DONE);
            if (abort) begin
                triggered <= 1'b0;
            end else if (accept) begin
                mask_q      <= trig_mask;
                value_q     <= trig_value;
                rise_q      <= trig_rise;
                fall_q      <= trig_fall;
                pre_q       <= pre_samples;
                div_q       <= sample_div;
                wptr_q      <= '0;
                tick_cnt_q  <= '0;
                pre_cnt_q   <= '0;
                have_prev_q <= 1'b0;
                triggered   <= 1'b0;
            end else if (tick) begin
                wptr_q      <= wptr_q + ADDR_W'(1);
                prev_q      <= signals_in;
                have_prev_q <= 1'b1;
                tick_cnt_q  <= div_q;
                if (state_q == ST_PREFILL) begin
                    pre_cnt_q <= pre_cnt_q + ADDR_W'(1);
                end
                if (fire) begin
                    trig_addr  <= wptr_q;
                    triggered  <= 1'b1;
                    post_rem_q <= post_len;
                end else if (state_q == ST_POST) begin
                    post_rem_q <= post_rem_q - ADDR_W'(1);
                end
            end else if (capturing) begin
                tick_cnt_q <= tick_cnt_q - 16'd1;
            end
        end
    end

    icetap_sample_ram #(
        .WIDTH (NR_SIGNALS),
        .DEPTH (RECORD_DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (tick),
        .waddr (wptr_q),
        .wdata (signals_in),
        .raddr (rd_phys),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_icetap_capture.sv
// Scoreboard bench for icetap_capture: a sample-stream model predicts trigger,
// completion and read-back contents; a separate monitor checks read data.
module tb_icetap_capture;

    localparam int W       = 8;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int PAT_LEN = 600;

    localparam int S_IDLE = 0, S_PREFILL = 1, S_ARMED = 2, S_POST = 3, S_DONE = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  signals_in = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  trig_mask = '0, trig_value = '0, trig_rise = '0, trig_fall = '0;
    logic [AW-1:0] pre_samples = '0;
    logic [15:0]   sample_div = '0;
    logic [2:0]    state;
    logic          triggered, done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;

    icetap_capture #(.NR_SIGNALS(W), .RECORD_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .signals_in  (signals_in),
        .start       (start),
        .abort       (abort),
        .trig_mask   (trig_mask),
        .trig_value  (trig_value),
        .trig_rise   (trig_rise),
        .trig_fall   (trig_fall),
        .pre_samples (pre_samples),
        .sample_div  (sample_div),
        .state       (state),
        .triggered   (triggered),
        .done        (done),
        .trig_addr   (trig_addr),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] pat [PAT_LEN];
    logic [W-1:0] rd_exp_q [$];
    logic         rd_req = 1'b0;
    logic         rd_vld = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Read data appears one cycle after the request.
    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            total++;
            if (rd_exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_data actual=%0h required=<none queued>", rd_data);
            end else begin
                logic [W-1:0] e;
                e = rd_exp_q.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL rd_data actual=%0h required=%0h", rd_data, e);
                end
            end
        end
    end

    function automatic bit trig_hit(input logic [W-1:0] cur, input logic [W-1:0] prev,
                                    input logic [W-1:0] m, input logic [W-1:0] v,
                                    input logic [W-1:0] r, input logic [W-1:0] f);
        bit lvl, ris, fal;
        lvl = (cur & m) == (v & m);
        ris = (r == 0) || ((r & ~prev & cur) != 0);
        fal = (f == 0) || ((f & prev & ~cur) != 0);
        return lvl && ris && fal;
    endfunction

    // Sample j is pat[j*stride]; first qualifying sample at or after pre is the trigger.
    task automatic model(input int div, input int pre, input logic [W-1:0] m, input logic [W-1:0] v,
                         input logic [W-1:0] r, input logic [W-1:0] f,
                         output int t_idx, output int end_idx);
        int stride;
        logic [W-1:0] cur, prev;
        stride = div + 1;
        t_idx  = -1;
        for (int j = pre; (j + DEPTH - 1 - pre) * stride < PAT_LEN; j++) begin
            cur  = pat[j * stride];
            prev = (j == 0) ? cur : pat[(j - 1) * stride];
            if (trig_hit(cur, prev, m, v, r, f)) begin
                t_idx = j;
                break;
            end
        end
        end_idx = t_idx + DEPTH - 1 - pre;
    endtask

    // mode: 0 normal, 1 abort once triggered, 2 reset in ARMED, 3 start pulse in ARMED.
    task automatic run_capture(input string name, input int div, input int pre,
                               input logic [W-1:0] m, input logic [W-1:0] v,
                               input logic [W-1:0] r, input logic [W-1:0] f, input int mode);
        int t_idx, end_idx, stride, seen_trig, seen_done, k;
        bit poked;
        model(div, pre, m, v, r, f, t_idx, end_idx);
        stride = div + 1;
        @(negedge clk);
        trig_mask = m; trig_value = v; trig_rise = r; trig_fall = f;
        pre_samples = AW'(pre); sample_div = 16'(div);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        trig_mask = W'($urandom); trig_value = W'($urandom);
        trig_rise = W'($urandom); trig_fall = W'($urandom);
        pre_samples = AW'($urandom); sample_div = 16'($urandom);
        check({name, "/first_state"}, int'(state), (pre == 0) ? S_ARMED : S_PREFILL);
        seen_trig = -1;
        seen_done = -1;
        poked = 1'b0;
        for (int c = 0; c < PAT_LEN; c++) begin
            signals_in = pat[c];
            if (start) begin
                start = 1'b0;
                check({name, "/start_ignored"}, int'(state == 3'(S_PREFILL)), 0);
            end
            if (triggered && seen_trig < 0) seen_trig = c;
            if (done) begin
                seen_done = c;
                break;
            end
            if (mode == 1 && seen_trig >= 0) begin
                check({name, "/post_state"}, int'(state), S_POST);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check({name, "/abort_state"}, int'(state), S_IDLE);
                check({name, "/abort_trig"}, int'(triggered), 0);
                check({name, "/abort_done"}, int'(done), 0);
                return;
            end
            if (mode == 2 && state == 3'(S_ARMED)) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check({name, "/reset_state"}, int'(state), S_IDLE);
                check({name, "/reset_done"}, int'(done), 0);
                check({name, "/reset_trig"}, int'(triggered), 0);
                return;
            end
            if (mode == 3 && state == 3'(S_ARMED) && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
            @(negedge clk);
        end
        check({name, "/trig_cycle"}, seen_trig, t_idx * stride + 1);
        check({name, "/done_cycle"}, seen_done, end_idx * stride + 1);
        check({name, "/trig_addr"}, int'(trig_addr), t_idx % DEPTH);
        if (seen_done < 0) return;
        k = $urandom_range(0, DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] a;
            a = AW'(i ^ k);
            rd_addr = a;
            rd_req  = 1'b1;
            rd_exp_q.push_back(pat[(t_idx - pre + int'(a)) * stride]);
            @(negedge clk);
        end
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check({name, "/still_done"}, int'(state), S_DONE);
    endtask

    task automatic fill_counter(input int base);
        for (int c = 0; c < PAT_LEN; c++) pat[c] = W'(base + c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_idx, end_idx, div, pre;
        logic [W-1:0] m, v, r, f;
        repeat (3) @(negedge clk);
        check("rst/state", int'(state), S_IDLE);
        check("rst/done", int'(done), 0);
        check("rst/triggered", int'(triggered), 0);
        check("rst/trig_addr", int'(trig_addr), 0);
        check("rst/rd_data", int'(rd_data), 0);
        reset = 1'b0;

        // Counter pattern, level trigger on 0x2A with 4 pre-trigger samples.
        fill_counter(8'h20);
        run_capture("counter", 0, 4, 8'hFF, 8'h2A, 8'h00, 8'h00, 0);

        // Rising edge of bit 0 toggling every 5 cycles, sampled every 3 cycles.
        for (int c = 0; c < PAT_LEN; c++) pat[c] = {7'($urandom), 1'((c / 5) % 2)};
        run_capture("rise", 2, 3, 8'h00, 8'h00, 8'h01, 8'h00, 0);

        // No prefill: trigger on the very first sample.
        for (int c = 0; c < PAT_LEN; c++) pat[c] = W'($urandom);
        run_capture("pre0", 0, 0, 8'hFF, pat[0], 8'h00, 8'h00, 0);

        // Maximum prefill: done directly after trigger.
        fill_counter(5);
        run_capture("pre15", 0, 15, 8'hFF, 8'd25, 8'h00, 8'h00, 0);

        // start and abort together from DONE/IDLE: abort wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort/state", int'(state), S_IDLE);

        fill_counter(8'h20);
        run_capture("abort_post", 0, 4, 8'hFF, 8'h2A, 8'h00, 8'h00, 1);

        fill_counter(0);
        run_capture("start_armed", 1, 5, 8'hFF, 8'h30, 8'h00, 8'h00, 3);

        fill_counter(0);
        run_capture("reset_armed", 0, 2, 8'hFF, 8'h80, 8'h00, 8'h00, 2);
        fill_counter(8'h20);
        run_capture("after_reset", 0, 4, 8'hFF, 8'h2A, 8'h00, 8'h00, 0);

        // Randomised captures with sparse trigger conditions.
        for (int n = 0; n < 6; n++) begin
            for (int c = 0; c < PAT_LEN; c++) pat[c] = W'($urandom);
            div = $urandom_range(0, 2);
            pre = $urandom_range(0, DEPTH - 1);
            m = W'($urandom & $urandom & $urandom);
            v = W'($urandom);
            r = ($urandom_range(0, 1) == 1) ? W'(1 << $urandom_range(0, W - 1)) : 8'h00;
            f = ($urandom_range(0, 1) == 1) ? W'(1 << $urandom_range(0, W - 1)) : 8'h00;
            model(div, pre, m, v, r, f, t_idx, end_idx);
            if (t_idx < 0) begin
                m = 8'h00; r = 8'h00; f = 8'h00;
            end
            run_capture($sformatf("rand%0d", n), div, pre, m, v, r, f, 0);
        end

        repeat (3) @(negedge clk);
        check("rd_queue_empty", rd_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icetap_capture.md
ICETAP_CAPTURE -- requirements
Module: icetap_capture

Interface
REQ-001 SHALL have parameter NR_SIGNALS, default 8: number of probed signals, 1..256.
REQ-002 SHALL have parameter RECORD_DEPTH, default 256: samples stored, power of two, 16..4096; ADDR_W = log2(RECORD_DEPTH).
REQ-003 SHALL have one clock and a synchronous, active-high reset: `clk` (input, 1, sole clock) and `reset` (input, 1, synchronous active-high reset).
REQ-004 Ports, other than `clk` and `reset`, SHALL be:
- signals_in  in  NR_SIGNALS  probed signals, synchronous to clk
- start  in  1  one-cycle pulse, arm capture
- abort  in  1  one-cycle pulse, cancel capture
- trig_mask  in  NR_SIGNALS  level-compare enable per bit
- trig_value  in  NR_SIGNALS  level-compare value
- trig_rise  in  NR_SIGNALS  rising-edge trigger enable per bit
- trig_fall  in  NR_SIGNALS  falling-edge trigger enable per bit
- pre_samples  in  ADDR_W  samples kept before trigger
- sample_div  in  16  sample tick every sample_div+1 cycles
- state  out  3  current FSM state
- triggered  out  1  trigger seen in this capture
- done  out  1  capture complete
- trig_addr  out  ADDR_W  physical address of trigger sample
- rd_addr  in  ADDR_W  logical read index, 0 = oldest sample
- rd_data  out  NR_SIGNALS  sample at rd_addr, one-cycle latency

Function
REQ-005 On start in IDLE or DONE, all trig_*, pre_samples and sample_div SHALL be latched; later changes SHALL have no effect until the next start.
REQ-006 FSM states SHALL be IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4.
REQ-007 start SHALL move IDLE/DONE to PREFILL, or to ARMED if the latched pre_samples==0; start SHALL be ignored in PREFILL/ARMED/POST.
REQ-008 abort SHALL move any state to IDLE on the next edge; if start and abort coincide, abort SHALL win.
REQ-009 The sample tick SHALL be asserted on the first cycle after entering PREFILL/ARMED, then every sample_div+1 cycles; sample_div=0 SHALL mean every cycle.
REQ-010 On each tick in PREFILL/ARMED/POST, signals_in SHALL be written to the write pointer and the pointer SHALL increment modulo RECORD_DEPTH (wrap-around).
REQ-011 The write pointer SHALL reset to 0 on every start.
REQ-012 PREFILL SHALL count pre_samples ticks, then enter ARMED; triggers SHALL be ignored in PREFILL.
REQ-013 The trigger condition, evaluated per tick in ARMED on the current sample versus the previous tick's sample, SHALL be:
- level: ((cur ^ trig_value) & trig_mask)==0; AND
- rise: trig_rise==0 OR any bit with trig_rise & ~prev & cur; AND
- fall: trig_fall==0 OR any bit with trig_fall & prev & ~cur.
REQ-014 The first ARMED tick SHALL use, as prev, the last sample stored in PREFILL, or the current sample when pre_samples==0 (no edge).
REQ-015 The trigger sample SHALL be stored, trig_addr set to its address, triggered set, and the FSM SHALL enter POST.
REQ-016 POST SHALL store exactly RECORD_DEPTH-1-pre_samples further ticks, then enter DONE; if that count is 0, DONE SHALL follow the trigger directly.
REQ-017 In DONE, rd_data SHALL be mem[(trig_addr - pre_samples + rd_addr) mod RECORD_DEPTH], registered, one cycle after rd_addr.
REQ-018 Reads SHALL be allowed in every state; contents are defined only in DONE.
REQ-019 done SHALL equal (state==DONE); triggered SHALL clear on start and abort.

Reset
REQ-020 reset SHALL force: state=IDLE, triggered=0, done=0, trig_addr=0, write pointer=0, tick counter=0, rd_data=0, latched config=0.
REQ-021 reset SHALL NOT be required to clear sample memory; reset mid-capture SHALL behave as abort.

Structure
REQ-022 A package icetap_pkg SHALL hold the state encoding constants.
REQ-023 Sample storage SHALL be one sub-module icetap_sample_ram: simple dual-port, one write port, one registered read port, inferable as block RAM.
REQ-024 All other logic SHALL be in icetap_capture.

Verification
REQ-025 DEPTH=16, pre=4, div=0, mask=0xFF, value=0x2A, counter on signals_in: start, 0x2A reached -> done; rd_addr 0..15 returns 0x26..0x35; rd_addr 4 returns 0x2A.
REQ-026 trig_rise=0x01, mask=0, div=2, bit0 toggled every 5 cycles: first stored 0->1 transition in ARMED triggers; stored samples are spaced 3 cycles apart.
REQ-027 pre=0, trigger true on the first tick: no PREFILL, and rd_addr 0 returns the trigger sample.
REQ-028 pre=15 with DEPTH=16: DONE one cycle after the trigger tick, and rd_addr 15 returns the trigger sample.
REQ-029 start+abort in the same cycle -> stays IDLE; abort in POST -> IDLE, triggered=0; start during ARMED -> ignored.
REQ-030 reset asserted in ARMED -> next cycle state=0, done=0, triggered=0; a new capture then completes normally.
